// File: rtl/load_store_unit.sv
// Load/store unit: turns MEM-stage requests into 32-bit beats on the data-memory port.
// Covers byte/half/word/dword accesses, sign/zero extension, dword splitting and
// read-modify-write for sub-word stores.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [63:0] resp_rdata,
  output logic        stall,
  output logic [63:0] Memory_Address,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] ReadData
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned BEAT = 32;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t            state;
  logic              op_write;
  logic              op_unsigned;
  logic [1:0]        op_size;
  logic [XLEN-1:0]   op_addr;
  logic [XLEN-1:0]   op_wdata;
  logic [BEAT-1:0]   rd0_word;

  logic [3:0]        req_bytes;
  logic [XLEN:0]     req_end;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic [XLEN-1:0]   req_beat0;
  logic [XLEN-1:0]   op_beat1;
  logic [BEAT-1:0]   rd_word;
  logic [BEAT-1:0]   rd_shift;
  logic [XLEN-1:0]   load_ext;
  logic [BEAT-1:0]   merged;
  logic              unused_rdata_hi;

  assign rd_word         = ReadData[BEAT-1:0];
  assign unused_rdata_hi = ^ReadData[XLEN-1:BEAT];
  assign req_beat0       = {req_addr[XLEN-1:2], 2'b00};
  assign op_beat1        = {op_addr[XLEN-1:2], 2'b00} + 64'd4;

  // Classify an incoming request as misaligned or outside the memory
  always_comb begin
    misaligned   = 1'b0;
    req_bytes    = 4'd1 << req_size;
    req_end      = {1'b0, req_addr} + 65'(req_bytes);
    case (req_size)
      SZ_HALF:  misaligned = req_addr[0];
      SZ_WORD:  misaligned = |req_addr[1:0];
      SZ_DWORD: misaligned = |req_addr[2:0];
      default:  misaligned = 1'b0;
    endcase
    out_of_range = req_end > 65'(MEM_BYTES);
    req_err      = misaligned | out_of_range;
  end

  // Select and extend the addressed lanes of the current read beat
  always_comb begin
    rd_shift = rd_word >> {op_addr[1:0], 3'b000};
    case (op_size)
      SZ_BYTE:  load_ext = op_unsigned ? {56'd0, rd_shift[7:0]}
                                       : {{56{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF:  load_ext = op_unsigned ? {48'd0, rd_shift[15:0]}
                                       : {{48{rd_shift[15]}}, rd_shift[15:0]};
      SZ_WORD:  load_ext = op_unsigned ? {32'd0, rd_shift}
                                       : {{32{rd_shift[31]}}, rd_shift};
      default:  load_ext = {32'd0, rd_shift};
    endcase
  end

  // Merge sub-word store data into the word read back during RD0
  always_comb begin
    merged = rd_word;
    if (op_size == SZ_BYTE) begin
      case (op_addr[1:0])
        2'd0:    merged[7:0]   = op_wdata[7:0];
        2'd1:    merged[15:8]  = op_wdata[7:0];
        2'd2:    merged[23:16] = op_wdata[7:0];
        default: merged[31:24] = op_wdata[7:0];
      endcase
    end else if (op_addr[1]) begin
      merged[31:16] = op_wdata[15:0];
    end else begin
      merged[15:0]  = op_wdata[15:0];
    end
  end

  // Access sequencer; every output is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
      stall          <= 1'b0;
      Memory_Address <= '0;
      Write_Data     <= '0;
      MemWrite       <= 1'b0;
      MemRead        <= 1'b0;
      op_write       <= 1'b0;
      op_unsigned    <= 1'b0;
      op_size        <= '0;
      op_addr        <= '0;
      op_wdata       <= '0;
      rd0_word       <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_write    <= req_write;
            op_unsigned <= req_unsigned;
            op_size     <= req_size;
            op_addr     <= req_addr;
            op_wdata    <= req_wdata;
            req_ready   <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && req_size[1]) begin
              state          <= WR0;
              stall          <= 1'b1;
              MemWrite       <= 1'b1;
              Memory_Address <= req_beat0;
              Write_Data     <= {32'd0, req_wdata[BEAT-1:0]};
            end else begin
              state          <= RD0;
              stall          <= 1'b1;
              MemRead        <= 1'b1;
              Memory_Address <= req_beat0;
            end
          end
        end
        RD0: begin
          rd0_word <= rd_word;
          MemRead  <= 1'b0;
          if (op_write) begin
            state      <= WR0;
            MemWrite   <= 1'b1;
            Write_Data <= {32'd0, merged};
          end else if (op_size == SZ_DWORD) begin
            state          <= RD1;
            MemRead        <= 1'b1;
            Memory_Address <= op_beat1;
          end else begin
            state      <= RESP;
            stall      <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_ext;
          end
        end
        RD1: begin
          MemRead    <= 1'b0;
          state      <= RESP;
          stall      <= 1'b0;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= {rd_word, rd0_word};
        end
        WR0: begin
          MemWrite <= 1'b0;
          if (op_size == SZ_DWORD) begin
            state          <= WR1;
            MemWrite       <= 1'b1;
            Memory_Address <= op_beat1;
            Write_Data     <= {32'd0, op_wdata[XLEN-1:BEAT]};
          end else begin
            state      <= RESP;
            stall      <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= '0;
          end
        end
        WR1: begin
          MemWrite   <= 1'b0;
          state      <= RESP;
          stall      <= 1'b0;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          stall     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          stall     <= 1'b0;
          MemRead   <= 1'b0;
          MemWrite  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-wide data memory, byte-level reference model,
// beat and response scoreboards checked from a negedge monitor.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int unsigned MEM = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_error, stall;
  logic [63:0] resp_rdata, Memory_Address, Write_Data, ReadData;
  logic        MemWrite, MemRead;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [31:0] data;
    int          cyc;
  } beat_t;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];

  logic [7:0] bus_mem [MEM];
  logic [7:0] ref_mem [MEM];

  load_store_unit #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
    .resp_rdata(resp_rdata), .stall(stall), .Memory_Address(Memory_Address),
    .Write_Data(Write_Data), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational memory read
  always_comb begin
    ReadData = '0;
    if (Memory_Address < 64'(MEM - 3))
      ReadData = {32'd0, bus_mem[Memory_Address + 3], bus_mem[Memory_Address + 2],
                  bus_mem[Memory_Address + 1], bus_mem[Memory_Address]};
  end

  // Memory write on the clock edge that ends a write beat
  always @(posedge clk) begin
    if (MemWrite && Memory_Address < 64'(MEM - 3)) begin
      for (int i = 0; i < 4; i++)
        bus_mem[Memory_Address + 64'(i)] <= Write_Data[8*i +: 8];
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  function automatic logic [31:0] ref_word(input logic [63:0] a);
    return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
  endfunction

  // Monitor: compare every beat and every response against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (MemRead || MemWrite) begin
        chk("rw_exclusive", 64'(MemRead & MemWrite), 64'd0);
        if (beat_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_kind", 64'(MemWrite), 64'(b.wr));
          chk("beat_addr", Memory_Address, b.addr);
          chk("beat_cycle", 64'(cyc), 64'(b.cyc));
          chk("beat_stall", 64'(stall), 64'd1);
          if (b.wr) chk("beat_wdata", Write_Data, {32'd0, b.data});
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          chk("resp_error", 64'(resp_error), 64'(r.err));
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
    end
  end

  // Reference model: expected beats and response of one access issued at cycle n
  task automatic model(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [63:0] a, input logic [63:0] wd, input int n);
    int nb;
    bit err;
    logic [63:0] base, val;
    resp_t r;
    nb   = 1 << sz;
    base = {a[63:2], 2'b00};
    err  = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           (sz == 2'd3 && a[2:0] != 3'd0) || (a >= 64'(MEM)) || (a + 64'(nb) > 64'(MEM));
    r.err = err;
    r.rdata = '0;
    if (err) begin
      r.cyc = n + 1;
    end else if (!wr) begin
      val = '0;
      for (int i = 0; i < nb; i++) val |= 64'(ref_mem[a + 64'(i)]) << (8 * i);
      if (!uns && nb < 8 && val[8*nb-1]) val |= {64{1'b1}} << (8 * nb);
      r.rdata = val;
      beat_q.push_back('{wr: 0, addr: base, data: 32'd0, cyc: n + 1});
      if (nb == 8) begin
        beat_q.push_back('{wr: 0, addr: base + 64'd4, data: 32'd0, cyc: n + 2});
        r.cyc = n + 3;
      end else begin
        r.cyc = n + 2;
      end
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[a + 64'(i)] = wd[8*i +: 8];
      if (nb == 8) begin
        beat_q.push_back('{wr: 1, addr: base, data: ref_word(base), cyc: n + 1});
        beat_q.push_back('{wr: 1, addr: base + 64'd4, data: ref_word(base + 64'd4), cyc: n + 2});
        r.cyc = n + 3;
      end else if (nb == 4) begin
        beat_q.push_back('{wr: 1, addr: base, data: ref_word(base), cyc: n + 1});
        r.cyc = n + 2;
      end else begin
        beat_q.push_back('{wr: 0, addr: base, data: 32'd0, cyc: n + 1});
        beat_q.push_back('{wr: 1, addr: base, data: ref_word(base), cyc: n + 2});
        r.cyc = n + 3;
      end
    end
    resp_q.push_back(r);
  endtask

  task automatic wait_ready(output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready;
    if (!ok) fail_now("req_ready_timeout");
  endtask

  task automatic drive(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [63:0] a, input logic [63:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    req_addr  = {$urandom, $urandom};
  endtask

  task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [63:0] a, input logic [63:0] wd);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      model(wr, sz, uns, a, wd, cyc);
      drive(wr, sz, uns, a, wd);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((beat_q.size() != 0 || resp_q.size() != 0) && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (beat_q.size() != 0 || resp_q.size() != 0) begin
      fail_now("scoreboard_not_drained");
      beat_q.delete();
      resp_q.delete();
    end
  endtask

  initial begin
    bit ok;
    logic [63:0] a, sd_data;
    logic [1:0]  sz;
    int          r;

    for (int i = 0; i < int'(MEM); i++) begin
      bus_mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    bus_mem[256] = 8'd7; ref_mem[256] = 8'd7;
    bus_mem[260] = 8'd6; ref_mem[260] = 8'd6;
    bus_mem[264] = 8'd5; ref_mem[264] = 8'd5;

    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_addr", Memory_Address, 64'd0);
    chk("rst_write_data", Write_Data, 64'd0);
    chk("rst_mem_strobes", {62'd0, MemWrite, MemRead}, 64'd0);

    // Directed accesses around the preloaded words
    issue(0, 2'd2, 0, 64'd256, 64'd0);
    issue(0, 2'd3, 0, 64'd256, 64'd0);
    issue(1, 2'd0, 0, 64'd257, 64'hAB);
    issue(0, 2'd2, 0, 64'd256, 64'd0);
    issue(0, 2'd0, 0, 64'd257, 64'd0);
    issue(0, 2'd0, 1, 64'd257, 64'd0);
    issue(0, 2'd1, 0, 64'd256, 64'd0);
    issue(0, 2'd2, 0, 64'd258, 64'd0);
    issue(0, 2'd2, 0, 64'd510, 64'd0);
    issue(0, 2'd3, 0, 64'd508, 64'd0);
    issue(1, 2'd1, 0, 64'd262, 64'h8001);
    issue(0, 2'd1, 0, 64'd262, 64'd0);
    issue(0, 2'd1, 1, 64'd262, 64'd0);
    drain();

    // Dword store aborted by reset during its second write beat
    sd_data = 64'h1122_3344_5566_7788;
    wait_ready(ok);
    if (ok) begin
      for (int i = 0; i < 4; i++) ref_mem[264 + i] = sd_data[8*i +: 8];
      beat_q.push_back('{wr: 1, addr: 64'd264, data: sd_data[31:0], cyc: cyc + 1});
      drive(1, 2'd3, 0, 64'd264, sd_data);
      @(posedge clk);
      #2;
      chk("wr1_strobe_before_reset", 64'(MemWrite), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("reset_drops_memwrite", 64'(MemWrite), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd1);
      chk("reset_resp_valid", 64'(resp_valid), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      beat_q.delete();
      @(negedge clk);
      chk("post_reset_req_ready", 64'(req_ready), 64'd1);
      for (int i = 268; i < 272; i++)
        chk("aborted_bytes_unchanged", 64'(bus_mem[i]), 64'(ref_mem[i]));
      issue(0, 2'd2, 0, 64'd268, 64'd0);
      issue(0, 2'd3, 0, 64'd264, 64'd0);
      drain();
    end

    // Randomized mix of sizes, directions and addresses
    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      if (r == 0)      a = 64'($urandom_range(500, 520));
      else if (r == 1) a = {$urandom, $urandom};
      else             a = 64'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Whole memory image must match the model
    for (int i = 0; i < int'(MEM); i += 4)
      chk("final_image", {32'd0, bus_mem[i+3], bus_mem[i+2], bus_mem[i+1], bus_mem[i]},
          {32'd0, ref_word(64'(i))});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
